// File: rtl/gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_capture
// Brief    : GPIO read side. Synchronises and debounces the pins, latches sticky
//            edge status with read-to-clear, and muxes bus read data.
// Revision : 1.0  initial release
// ============================================================================
module gpio_in_capture #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpi,
    input  logic [WIDTH-1:0] gpo1,
    input  logic [WIDTH-1:0] gpo2,
    input  logic [1:0]       rdsel,
    input  logic             re,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   r_q;
    logic [c_CNT_W-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0]   r_status;
    logic               r_irq;

    logic [WIDTH-1:0]   w_s;
    logic [WIDTH-1:0]   w_q_next;
    logic [c_CNT_W-1:0] w_cnt_next [WIDTH];
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_event;
    logic [WIDTH-1:0]   w_status_next;
    logic               w_clear;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A bit only changes q after it has differed from q for DEBOUNCE_CYCLES
    // consecutive synced cycles; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_q_next[i]   = r_q[i];
            w_cnt_next[i] = '0;
            if (w_s[i] != r_q[i]) begin
                if (r_cnt[i] == c_CNT_MAX) begin
                    w_q_next[i] = w_s[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    assign w_rise = w_q_next & ~r_q;
    assign w_fall = ~w_q_next & r_q;

    generate
        if (EDGE_MODE == 0) begin : g_edge_rise
            assign w_event = w_rise;
        end else if (EDGE_MODE == 1) begin : g_edge_fall
            assign w_event = w_fall;
        end else begin : g_edge_both
            assign w_event = w_rise | w_fall;
        end
    endgenerate

    // New events are ORed in after the clear so they survive a coincident read.
    assign w_clear       = re && (rdsel == 2'b01);
    assign w_status_next = (w_clear ? '0 : r_status) | w_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_q      <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync[0] <= gpi;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_q      <= w_q_next;
            r_status <= w_status_next;
            r_irq    <= |w_status_next;
        end
    end

    always_comb begin
        case (rdsel)
            2'b00:   rd = r_q;
            2'b01:   rd = r_status;
            2'b10:   rd = gpo1;
            2'b11:   rd = gpo2;
            default: rd = '0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire
